bf_weight_ctrl: RTL and testbench



---
 rtl/bf_pkg.sv | 26 ++
 rtl/bf_weight_ctrl_if.sv | 23 ++
 rtl/bf_weight_bank.sv | 48 ++++
 rtl/bf_weight_ctrl.sv | 105 ++++++++++
 tb/tb_bf_weight_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bf_pkg.sv
// Shared constants and types for the beamformer weight controller.
// Bank entry index = {channel, table}, so a config address maps straight to an entry.
package bf_pkg;

  localparam int BF_NCH = 8;
  localparam int BF_WW  = 5;
  localparam int BF_AW  = 5;

  localparam logic [1:0] TBL_COS1 = 2'd0;
  localparam logic [1:0] TBL_SIN1 = 2'd1;
  localparam logic [1:0] TBL_COS2 = 2'd2;
  localparam logic [1:0] TBL_SIN2 = 2'd3;

  localparam logic [BF_WW-1:0] BF_RST_COS = 5'd15;
  localparam logic [BF_WW-1:0] BF_RST_SIN = 5'd0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } bf_state_e;

  function automatic logic is_cos_tbl(input logic [1:0] tbl);
    return (tbl == TBL_COS1) || (tbl == TBL_COS2);
  endfunction

endpackage

// File: rtl/bf_weight_ctrl_if.sv
// Weight-write and commit handshake between a configuration source and bf_weight_ctrl.
interface bf_weight_ctrl_if #(
  parameter int WW = bf_pkg::BF_WW
) ();
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [bf_pkg::BF_AW-1:0] cfg_addr;
  logic [WW-1:0]        cfg_data;
  logic                 commit_req;
  logic                 commit_busy;
  logic                 commit_done;
  logic [7:0]           epoch;

  modport master (
    output cfg_valid, cfg_addr, cfg_data, commit_req,
    input  cfg_ready, commit_busy, commit_done, epoch
  );

  modport slave (
    input  cfg_valid, cfg_addr, cfg_data, commit_req,
    output cfg_ready, commit_busy, commit_done, epoch
  );
endinterface

// File: rtl/bf_weight_bank.sv
// 4*NCH-entry weight register file: single-entry write port, whole-bank load, full read-out.
// Load takes priority over write; the controller never asserts both together.
module bf_weight_bank
  import bf_pkg::*;
#(
  parameter int               NCH     = BF_NCH,
  parameter int               WW      = BF_WW,
  parameter logic [WW-1:0]    RST_COS = BF_RST_COS
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          we_i,
  input  logic [BF_AW-1:0]              waddr_i,
  input  logic [WW-1:0]                 wdata_i,
  input  logic                          load_i,
  input  logic [4*NCH-1:0][WW-1:0]      load_bank_i,
  output logic [4*NCH-1:0][WW-1:0]      bank_o
);

  logic [4*NCH-1:0][WW-1:0] mem_q, mem_d, dflt;

  always_comb begin
    dflt = '0;
    for (int e = 0; e < 4*NCH; e++) begin
      dflt[e] = is_cos_tbl(2'(e)) ? RST_COS : '0;
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (load_i) begin
      mem_d = load_bank_i;
    end else if (we_i) begin
      mem_d[waddr_i] = wdata_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q <= dflt;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign bank_o = mem_q;

endmodule

// File: rtl/bf_weight_ctrl.sv
// Shadow/active weight controller: writes land in the shadow bank, a commit copies the
// whole shadow into the active bank on the phase_i==0 edge so all channels switch together.
module bf_weight_ctrl
  import bf_pkg::*;
#(
  parameter int            NCH     = BF_NCH,
  parameter int            WW      = BF_WW,
  parameter logic [WW-1:0] RST_COS = BF_RST_COS
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [2:0]              phase_i,
  bf_weight_ctrl_if.slave         cfg,
  output logic [NCH-1:0][WW-1:0]  w_cos_1_o,
  output logic [NCH-1:0][WW-1:0]  w_sin_1_o,
  output logic [NCH-1:0][WW-1:0]  w_cos_2_o,
  output logic [NCH-1:0][WW-1:0]  w_sin_2_o
);

  bf_state_e  state_q, state_d;
  logic [7:0] epoch_q, epoch_d;
  logic       done_q, done_d;
  logic       load;
  logic       shadow_we;

  logic [4*NCH-1:0][WW-1:0] shadow_bank, active_bank;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      epoch_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      epoch_q <= epoch_d;
      done_q  <= done_d;
    end
  end

  // Loading on the phase 0->1 edge leaves three clocks before the next prescale rise.
  always_comb begin
    state_d         = state_q;
    epoch_d         = epoch_q;
    done_d          = 1'b0;
    load            = 1'b0;
    cfg.cfg_ready   = 1'b0;
    cfg.commit_busy = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cfg.cfg_ready = 1'b1;
        if (cfg.commit_req) state_d = ST_PEND;
      end
      ST_PEND: begin
        cfg.commit_busy = 1'b1;
        if (phase_i == 3'd0) begin
          load    = 1'b1;
          done_d  = 1'b1;
          epoch_d = epoch_q + 8'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cfg.commit_done = done_q;
  assign cfg.epoch       = epoch_q;
  assign shadow_we       = cfg.cfg_valid & cfg.cfg_ready;

  bf_weight_bank #(.NCH(NCH), .WW(WW), .RST_COS(RST_COS)) u_shadow (
    .clock       (clock),
    .reset       (reset),
    .we_i        (shadow_we),
    .waddr_i     (cfg.cfg_addr),
    .wdata_i     (cfg.cfg_data),
    .load_i      (1'b0),
    .load_bank_i ('0),
    .bank_o      (shadow_bank)
  );

  bf_weight_bank #(.NCH(NCH), .WW(WW), .RST_COS(RST_COS)) u_active (
    .clock       (clock),
    .reset       (reset),
    .we_i        (1'b0),
    .waddr_i     ('0),
    .wdata_i     ('0),
    .load_i      (load),
    .load_bank_i (shadow_bank),
    .bank_o      (active_bank)
  );

  always_comb begin
    w_cos_1_o = '0;
    w_sin_1_o = '0;
    w_cos_2_o = '0;
    w_sin_2_o = '0;
    for (int c = 0; c < NCH; c++) begin
      w_cos_1_o[c] = active_bank[4*c + int'(TBL_COS1)];
      w_sin_1_o[c] = active_bank[4*c + int'(TBL_SIN1)];
      w_cos_2_o[c] = active_bank[4*c + int'(TBL_COS2)];
      w_sin_2_o[c] = active_bank[4*c + int'(TBL_SIN2)];
    end
  end

endmodule

// File: tb/tb_bf_weight_ctrl.sv
// Bench for bf_weight_ctrl: directed scenarios plus random traffic, checked every cycle
// against a cycle-count based model of shadow/active banks and commit timing.
module tb_bf_weight_ctrl;
  import bf_pkg::*;

  localparam int NCH = 8;
  localparam int WW  = 5;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] phase_i = 3'd0;
  logic [NCH-1:0][WW-1:0] w_cos_1_o, w_sin_1_o, w_cos_2_o, w_sin_2_o;

  bf_weight_ctrl_if #(.WW(WW)) cfg ();

  bf_weight_ctrl #(.NCH(NCH), .WW(WW), .RST_COS(5'd15)) dut (
    .clock     (clock),
    .reset     (reset),
    .phase_i   (phase_i),
    .cfg       (cfg),
    .w_cos_1_o (w_cos_1_o),
    .w_sin_1_o (w_sin_1_o),
    .w_cos_2_o (w_cos_2_o),
    .w_sin_2_o (w_sin_2_o)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: banks as plain arrays; a commit lands a computed number of edges after the request.
  logic [WW-1:0] sh_m [32];
  logic [WW-1:0] ac_m [32];
  logic [7:0]    epoch_m;
  bit            pend_m, done_m, mvalid;
  longint        cyc, load_at;

  function automatic logic [WW-1:0] dflt_of(input int e);
    return (e % 4 == 0 || e % 4 == 2) ? 5'd15 : 5'd0;
  endfunction

  always @(posedge clock) begin
    phase_i <= phase_i + 3'd1;
    if (reset) begin
      for (int e = 0; e < 32; e++) begin
        sh_m[e] = dflt_of(e);
        ac_m[e] = dflt_of(e);
      end
      epoch_m = 0;
      pend_m  = 0;
      done_m  = 0;
      mvalid  = 1;
    end else begin
      done_m = 0;
      if (pend_m) begin
        if (cyc == load_at) begin
          for (int e = 0; e < 32; e++) ac_m[e] = sh_m[e];
          epoch_m = epoch_m + 8'd1;
          done_m  = 1;
          pend_m  = 0;
        end
      end else begin
        if (cfg.cfg_valid) sh_m[cfg.cfg_addr] = cfg.cfg_data;
        if (cfg.commit_req) begin
          pend_m  = 1;
          load_at = cyc + ((phase_i == 3'd0) ? 8 : 8 - longint'(phase_i));
        end
      end
    end
    cyc++;
  end

  function automatic logic [NCH*WW-1:0] exp_tbl(input int t);
    logic [NCH*WW-1:0] v;
    v = '0;
    for (int c = 0; c < NCH; c++) v[c*WW +: WW] = ac_m[c*4 + t];
    return v;
  endfunction

  always @(negedge clock) begin
    if (mvalid) begin
      chk("cfg_ready",   cfg.cfg_ready,   !pend_m);
      chk("commit_busy", cfg.commit_busy, pend_m);
      chk("commit_done", cfg.commit_done, done_m);
      chk("epoch",       cfg.epoch,       epoch_m);
      chk("w_cos_1", w_cos_1_o, exp_tbl(0));
      chk("w_sin_1", w_sin_1_o, exp_tbl(1));
      chk("w_cos_2", w_cos_2_o, exp_tbl(2));
      chk("w_sin_2", w_sin_2_o, exp_tbl(3));
      if (cfg.commit_done === 1'b1) n_done++;
    end
  end

  task automatic wait_phase(input logic [2:0] p);
    int k;
    k = 0;
    while (phase_i != p && k < 16) begin
      @(negedge clock);
      k++;
    end
    if (phase_i != p) chk("phase_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (cfg.commit_done !== 1'b1 && k < 20) begin
      @(negedge clock);
      k++;
    end
    if (cfg.commit_done !== 1'b1) chk("done_timeout", 0, 1);
  endtask

  task automatic idle_inputs();
    cfg.cfg_valid  = 1'b0;
    cfg.commit_req = 1'b0;
  endtask

  logic [NCH*WW-1:0] cos_dflt;
  int busy_cnt, done_before, k;

  initial begin
    cfg.cfg_valid  = 1'b0;
    cfg.cfg_addr   = '0;
    cfg.cfg_data   = '0;
    cfg.commit_req = 1'b0;
    for (int c = 0; c < NCH; c++) cos_dflt[c*WW +: WW] = 5'd15;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_cos1_lit", w_cos_1_o, cos_dflt);
    chk("rst_cos2_lit", w_cos_2_o, cos_dflt);
    chk("rst_sin1_lit", w_sin_1_o, 0);
    chk("rst_ready_lit", cfg.cfg_ready, 1);
    chk("rst_epoch_lit", cfg.epoch, 0);

    // ch3/sin1 = 9 held in shadow only
    cfg.cfg_valid = 1'b1; cfg.cfg_addr = 5'd13; cfg.cfg_data = 5'd9;
    @(negedge clock);
    idle_inputs();
    repeat (50) @(negedge clock);
    chk("sin1_ch3_uncommitted_lit", w_sin_1_o[3], 0);

    // Request sampled at phase 7 loads on the next edge
    wait_phase(3'd7);
    cfg.commit_req = 1'b1;
    @(negedge clock);
    cfg.commit_req = 1'b0;
    chk("busy_after_req_lit", cfg.commit_busy, 1);
    @(negedge clock);
    chk("sin1_ch3_commit_lit", w_sin_1_o[3], 9);
    chk("done_p7_lit", cfg.commit_done, 1);
    chk("epoch1_lit", cfg.epoch, 1);
    @(negedge clock);
    chk("done_single_lit", cfg.commit_done, 0);

    // Request sampled at phase 0: 8 busy cycles, write held off until done
    wait_phase(3'd0);
    cfg.commit_req = 1'b1;
    @(negedge clock);
    cfg.commit_req = 1'b0;
    cfg.cfg_valid = 1'b1; cfg.cfg_addr = 5'd20; cfg.cfg_data = 5'd7;
    busy_cnt = 0;
    while (cfg.commit_busy === 1'b1 && busy_cnt < 20) begin
      busy_cnt++;
      @(negedge clock);
    end
    chk("busy_len_p0_lit", busy_cnt, 8);
    chk("done_after_p0_lit", cfg.commit_done, 1);
    chk("ready_after_p0_lit", cfg.cfg_ready, 1);
    @(negedge clock);
    cfg.cfg_valid = 1'b0;
    chk("cos1_ch5_not_active_lit", w_cos_1_o[5], 15);

    // Simultaneous write + commit, then a second ignored request
    wait_phase(3'd3);
    cfg.cfg_valid = 1'b1; cfg.cfg_addr = 5'd2; cfg.cfg_data = 5'd4;
    cfg.commit_req = 1'b1;
    done_before = n_done;
    @(negedge clock);
    idle_inputs();
    @(negedge clock);
    cfg.commit_req = 1'b1;
    @(negedge clock);
    cfg.commit_req = 1'b0;
    repeat (20) @(negedge clock);
    chk("one_done_lit", n_done - done_before, 1);
    chk("cos2_ch0_lit", w_cos_2_o[0], 4);
    chk("cos1_ch5_committed_lit", w_cos_1_o[5], 7);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cfg.cfg_valid  = ($urandom_range(1) == 1);
      cfg.cfg_addr   = 5'($urandom_range(31));
      cfg.cfg_data   = 5'($urandom_range(31));
      cfg.commit_req = ($urandom_range(9) == 0);
      @(negedge clock);
    end
    idle_inputs();
    repeat (12) @(negedge clock);

    // Reset during a pending commit discards it
    cfg.cfg_valid = 1'b1; cfg.cfg_addr = 5'd31; cfg.cfg_data = 5'd21;
    @(negedge clock);
    wait_phase(3'd1);
    cfg.cfg_valid = 1'b0;
    cfg.commit_req = 1'b1;
    done_before = n_done;
    @(negedge clock);
    cfg.commit_req = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    chk("no_done_after_rst_lit", n_done - done_before, 0);
    chk("rst_sin2_lit", w_sin_2_o, 0);
    chk("rst_cos1_again_lit", w_cos_1_o, cos_dflt);
    chk("rst_epoch0_lit", cfg.epoch, 0);

    // 256 commits wrap epoch back to 0
    for (int n = 1; n <= 256; n++) begin
      cfg.commit_req = 1'b1;
      @(negedge clock);
      cfg.commit_req = 1'b0;
      wait_done();
      if (n == 255) chk("epoch255_lit", cfg.epoch, 255);
      @(negedge clock);
    end
    chk("epoch_wrap_lit", cfg.epoch, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    k = 0;
    #1000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
